// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync pulses, active flag and strobes.
// Sync/active/strobes are derived from the next-state counters so they never skew from the coordinates.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int PIX_DIV  = 1
) (
  input  logic        CLK,
  input  logic        RESETN,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        PIX_TICK,
  output logic        LINE_START,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || PIX_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: totals must fit 12-bit counters and PIX_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [11:0]      horz_q, horz_d, vert_q, vert_d;
  logic             hs_q, hs_d, vs_q, vs_d, active_q, active_d;
  logic             pix_tick_q, pix_tick_d, line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             advance;

  always_comb begin
    advance = (div_q == DIV_W'(PIX_DIV - 1));
    div_d   = advance ? '0 : div_q + DIV_W'(1);
    horz_d  = horz_q;
    vert_d  = vert_q;
    if (advance) begin
      if (horz_q == H_LAST) begin
        horz_d = '0;
        vert_d = (vert_q == V_LAST) ? 12'd0 : vert_q + 12'd1;
      end else begin
        horz_d = horz_q + 12'd1;
      end
    end
    // Between advances the next-state counters equal the current ones, so these simply hold.
    hs_d          = ((horz_d >= HS_FIRST) && (horz_d <= HS_LAST)) ? H_POL : ~H_POL;
    vs_d          = ((vert_d >= VS_FIRST) && (vert_d <= VS_LAST)) ? V_POL : ~V_POL;
    active_d      = (horz_d < H_ACT) && (vert_d < V_ACT);
    pix_tick_d    = advance;
    line_start_d  = advance && (horz_d == 12'd0);
    frame_start_d = line_start_d && (vert_d == 12'd0);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_q         <= '0;
      horz_q        <= H_LAST;
      vert_q        <= V_LAST;
      hs_q          <= ~H_POL;
      vs_q          <= ~V_POL;
      active_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      horz_q        <= horz_d;
      vert_q        <= vert_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign VGA_horzCoord = horz_q;
  assign VGA_vertCoord = vert_q;
  assign VGA_HS        = hs_q;
  assign VGA_VS        = vs_q;
  assign VGA_active    = active_q;
  assign PIX_TICK      = pix_tick_q;
  assign LINE_START    = line_start_q;
  assign FRAME_START   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: full-size raster plus a small
// active-low, PIX_DIV=4 raster that is short enough to run whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  always #5 clk = ~clk;

  logic [11:0] h_a, v_a, h_b, v_b;
  logic hs_a, vs_a, act_a, pt_a, ls_a, fs_a;
  logic hs_b, vs_b, act_b, pt_b, ls_b, fs_b;

  vga_timing_gen dut_a (
    .CLK(clk), .RESETN(rst_n_a),
    .VGA_horzCoord(h_a), .VGA_vertCoord(v_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_active(act_a), .PIX_TICK(pt_a), .LINE_START(ls_a), .FRAME_START(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(4)
  ) dut_b (
    .CLK(clk), .RESETN(rst_n_b),
    .VGA_horzCoord(h_b), .VGA_vertCoord(v_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_active(act_b), .PIX_TICK(pt_b), .LINE_START(ls_b), .FRAME_START(fs_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int edges;
    int h;
    int v;
    bit hs;
    bit vs;
    bit act;
    bit ls;
    bit fs;
    bit pt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cur;
    int n_hs, n_act, n_ls, n_pt, n_fs, n_vs;
    int first_hs_h, fall_hs_h, bad_vs, bad_hold, bad_range;
    logic [11:0] prev_h, prev_v;
    logic prev_vs, prev_hs;

    // edges since reset release -> expected full-size raster outputs
    tbl[0]  = '{1,    0,    0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    1,    0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1280, 1279, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1281, 1280, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1328, 1327, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1329, 1328, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1440, 1439, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1441, 1440, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1688, 1687, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1689, 0,    1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1690, 1,    1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{3377, 0,    2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) tick();

    chk("rst_h", int'(h_a), 1687);
    chk("rst_v", int'(v_a), 1065);
    chk("rst_act", int'(act_a), 0);
    chk("rst_hs", int'(hs_a), 0);
    chk("rst_vs", int'(vs_a), 0);
    chk("rst_strobes", int'({pt_a, ls_a, fs_a}), 0);

    rst_n_a = 1'b1;
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].edges) begin
        tick();
        cur++;
      end
      chk($sformatf("e%0d_h", tbl[i].edges), int'(h_a), tbl[i].h);
      chk($sformatf("e%0d_v", tbl[i].edges), int'(v_a), tbl[i].v);
      chk($sformatf("e%0d_hs", tbl[i].edges), int'(hs_a), int'(tbl[i].hs));
      chk($sformatf("e%0d_vs", tbl[i].edges), int'(vs_a), int'(tbl[i].vs));
      chk($sformatf("e%0d_act", tbl[i].edges), int'(act_a), int'(tbl[i].act));
      chk($sformatf("e%0d_ls", tbl[i].edges), int'(ls_a), int'(tbl[i].ls));
      chk($sformatf("e%0d_fs", tbl[i].edges), int'(fs_a), int'(tbl[i].fs));
      chk($sformatf("e%0d_pt", tbl[i].edges), int'(pt_a), int'(tbl[i].pt));
    end

    // Async reset mid-line, asserted between clock edges.
    repeat (700) tick();
    chk("mid_h", int'(h_a), 700);
    chk("mid_v", int'(v_a), 2);
    #1 rst_n_a = 1'b0;
    #1;
    chk("async_h", int'(h_a), 1687);
    chk("async_v", int'(v_a), 1065);
    chk("async_act_hs_vs", int'({act_a, hs_a, vs_a}), 0);
    chk("async_strobes", int'({pt_a, ls_a, fs_a}), 0);
    tick();
    chk("held_h", int'(h_a), 1687);
    rst_n_a = 1'b1;
    tick();
    chk("restart_hv", int'({h_a, v_a}), 0);
    chk("restart_fs_ls_pt", int'({fs_a, ls_a, pt_a}), 7);

    // One full line: sync width and edges, active width, single line start.
    n_hs = 0; n_act = 0; n_ls = 0;
    first_hs_h = -1; fall_hs_h = -1;
    prev_hs = hs_a;
    for (int i = 0; i < 1688; i++) begin
      if (i > 0) tick();
      if (hs_a && !prev_hs && first_hs_h < 0) first_hs_h = int'(h_a);
      if (!hs_a && prev_hs && fall_hs_h < 0) fall_hs_h = int'(h_a);
      prev_hs = hs_a;
      n_hs  += int'(hs_a);
      n_act += int'(act_a);
      n_ls  += int'(ls_a);
    end
    chk("line_hs_cycles", n_hs, 112);
    chk("line_hs_rise_h", first_hs_h, 1328);
    chk("line_hs_fall_h", fall_hs_h, 1440);
    chk("line_act_cycles", n_act, 1280);
    chk("line_ls_count", n_ls, 1);

    // Small raster: active-low syncs, 16x8 totals, 4 clocks per pixel.
    chk("b_rst_h", int'(h_b), 15);
    chk("b_rst_v", int'(v_b), 7);
    chk("b_rst_syncs", int'({hs_b, vs_b}), 3);
    chk("b_rst_act", int'(act_b), 0);
    rst_n_b = 1'b1;
    repeat (3) tick();
    chk("b_wait_h", int'(h_b), 15);
    chk("b_wait_pt", int'(pt_b), 0);
    tick();
    chk("b_first_hv", int'({h_b, v_b}), 0);
    chk("b_first_strobes", int'({pt_b, ls_b, fs_b}), 7);
    chk("b_first_act_syncs", int'({act_b, hs_b, vs_b}), 7);

    n_pt = 0; n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_act = 0;
    bad_vs = 0; bad_hold = 0; bad_range = 0;
    prev_h = h_b; prev_v = v_b; prev_vs = vs_b;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) begin
        tick();
        if (!pt_b && (h_b != prev_h || v_b != prev_v)) bad_hold++;
        if (vs_b != prev_vs && h_b != 12'd0) bad_vs++;
      end
      if (h_b >= 12'd16 || v_b >= 12'd8) bad_range++;
      prev_h = h_b; prev_v = v_b; prev_vs = vs_b;
      n_pt  += int'(pt_b);
      n_ls  += int'(ls_b);
      n_fs  += int'(fs_b);
      n_hs  += int'(!hs_b);
      n_vs  += int'(!vs_b);
      n_act += int'(act_b);
    end
    chk("b_frame_pt", n_pt, 128);
    chk("b_frame_ls", n_ls, 8);
    chk("b_frame_fs", n_fs, 1);
    chk("b_frame_hs_low", n_hs, 96);
    chk("b_frame_vs_low", n_vs, 128);
    chk("b_frame_act", n_act, 128);
    chk("b_hold_between_ticks", bad_hold, 0);
    chk("b_vs_edge_at_h0", bad_vs, 0);
    chk("b_range", bad_range, 0);
    tick();
    chk("b_next_frame_fs", int'(fs_b), 1);
    chk("b_next_frame_hv", int'({h_b, v_b}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
